tm1638_key_event: RTL and testbench

- Sits directly downstream of the TM1638 LED/KEY driver and consumes its 8-bit scanned key vector (KEYS_o).
- Debounces each key on a slow sample tick and produces per-key press, release and auto-repeat pulses plus a toggle register per key.
- Serializes all events into a small show-ahead FIFO with a valid/ready handshake.
- Replaces ad-hoc edge logic at top level, e.g. the display-mode toggle.

---
 rtl/tm1638_key_event.sv | 205 ++++++++++++++++++++
 tb/tb_tm1638_key_event.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_event.sv
// Key event processor for the TM1638 scanned key vector: per-key debounce, press/release/
// auto-repeat pulses, toggle bits, and a serialized event stream through a show-ahead FIFO.
module tm1638_key_event #(
  parameter int unsigned C_FCK        = 48_000_000,
  parameter int unsigned C_FTICK      = 1_000,
  parameter int unsigned C_DEB_N      = 8,
  parameter int unsigned C_REP_DLY    = 500,
  parameter int unsigned C_REP_PER    = 100,
  parameter int unsigned C_FIFO_DEPTH = 4
) (
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic [7:0] KEYS_i,
  output logic [7:0] STATE_o,
  output logic [7:0] PRESS_o,
  output logic [7:0] RELEASE_o,
  output logic [7:0] REPEAT_o,
  output logic [7:0] TOGGLE_o,
  input  logic       TOGGLE_CLR_i,
  output logic       EV_VALID_o,
  output logic [4:0] EV_DAT_o,
  input  logic       EV_READY_i,
  output logic       EV_OVF_o,
  input  logic       OVF_CLR_i
);

  localparam int unsigned DIV = C_FCK / C_FTICK;
  localparam int unsigned TW  = $clog2(DIV);
  localparam int unsigned DW  = $clog2(C_DEB_N + 1);
  localparam int unsigned HW  = $clog2(C_REP_DLY + C_REP_PER + 1);
  localparam int unsigned AW  = $clog2(C_FIFO_DEPTH);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_type_e;

  logic [7:0]    keys_d;
  logic [TW-1:0] tick_ctr;
  logic          tick;

  logic [DW-1:0] deb_ctr  [8];
  logic [DW-1:0] deb_n    [8];
  logic [HW-1:0] hold_ctr [8];
  logic [HW-1:0] hold_n   [8];
  logic [7:0]    state_n;
  logic [7:0]    press_n;
  logic [7:0]    rel_n;
  logic [7:0]    rep_n;

  logic [23:0]   pend;
  logic [23:0]   new_ev;
  logic [23:0]   pick;
  logic [2:0]    ev_key;
  ev_type_e      ev_type;
  logic          wr_vld;
  logic [4:0]    wr_dat;

  logic [4:0]    mem [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign tick = (tick_ctr == '0);

  always_comb begin
    state_n = STATE_o;
    press_n = '0;
    rel_n   = '0;
    rep_n   = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      deb_n[n]  = deb_ctr[n];
      hold_n[n] = hold_ctr[n];
      if (!STATE_o[n])
        hold_n[n] = '0;
      if (tick) begin
        if (keys_d[n] != STATE_o[n]) begin
          if (deb_ctr[n] == DW'(C_DEB_N - 1)) begin
            state_n[n] = keys_d[n];
            deb_n[n]   = '0;
            press_n[n] = keys_d[n];
            rel_n[n]   = ~keys_d[n];
          end else begin
            deb_n[n] = deb_ctr[n] + 1'b1;
          end
        end else begin
          deb_n[n] = '0;
        end
        // Hold counter stops at DLY+PER and reloads to DLY, so it never needs to wrap.
        if (STATE_o[n]) begin
          if (hold_ctr[n] == HW'(C_REP_DLY - 1)) begin
            hold_n[n] = hold_ctr[n] + 1'b1;
            rep_n[n]  = 1'b1;
          end else if (hold_ctr[n] == HW'(C_REP_DLY + C_REP_PER - 1)) begin
            hold_n[n] = HW'(C_REP_DLY);
            rep_n[n]  = 1'b1;
          end else begin
            hold_n[n] = hold_ctr[n] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    new_ev = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      new_ev[3*n]   = press_n[n];
      new_ev[3*n+1] = rel_n[n];
      new_ev[3*n+2] = rep_n[n];
    end
  end

  // Descending scan: the last hit is the lowest set bit, i.e. lowest key, press first.
  always_comb begin
    pick    = '0;
    ev_key  = '0;
    ev_type = EV_PRESS;
    for (int unsigned i = 24; i > 0; i--) begin
      if (pend[i-1]) begin
        pick   = 24'(1) << (i - 1);
        ev_key = 3'((i - 1) / 3);
        case ((i - 1) % 3)
          0:       ev_type = EV_PRESS;
          1:       ev_type = EV_RELEASE;
          default: ev_type = EV_REPEAT;
        endcase
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      keys_d    <= '0;
      tick_ctr  <= TW'(DIV - 1);
      STATE_o   <= '0;
      PRESS_o   <= '0;
      RELEASE_o <= '0;
      REPEAT_o  <= '0;
      TOGGLE_o  <= '0;
      pend      <= '0;
      wr_vld    <= 1'b0;
      wr_dat    <= '0;
      for (int unsigned n = 0; n < 8; n++) begin
        deb_ctr[n]  <= '0;
        hold_ctr[n] <= '0;
      end
    end else begin
      keys_d    <= KEYS_i;
      tick_ctr  <= tick ? TW'(DIV - 1) : tick_ctr - 1'b1;
      STATE_o   <= state_n;
      PRESS_o   <= press_n;
      RELEASE_o <= rel_n;
      REPEAT_o  <= rep_n;
      TOGGLE_o  <= TOGGLE_CLR_i ? '0 : (TOGGLE_o ^ press_n);
      pend      <= (pend & ~pick) | new_ev;
      wr_vld    <= |pend;
      wr_dat    <= {ev_type, ev_key};
      for (int unsigned n = 0; n < 8; n++) begin
        deb_ctr[n]  <= deb_n[n];
        hold_ctr[n] <= hold_n[n];
      end
    end
  end

  assign full       = (cnt == (AW+1)'(C_FIFO_DEPTH));
  assign EV_VALID_o = (cnt != '0);
  assign pop        = EV_VALID_o & EV_READY_i;
  assign push       = wr_vld & (~full | pop);
  assign drop       = wr_vld & full & ~pop;
  assign EV_DAT_o   = EV_VALID_o ? mem[rd_ptr] : '0;

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      EV_OVF_o <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      if (drop)
        EV_OVF_o <= 1'b1;
      else if (OVF_CLR_i)
        EV_OVF_o <= 1'b0;
    end
  end

  always_ff @(posedge CK_i) begin
    if (push)
      mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: tb/tb_tm1638_key_event.sv
// Bench for tm1638_key_event: directed scenarios plus a randomized run against a
// tick-level behavioural model of debounce, repeat, toggle and event ordering.
module tb_tm1638_key_event;

  localparam int DIV = 10;
  localparam int DEB = 3;
  localparam int DLY = 5;
  localparam int PER = 2;

  logic       CK_i = 1'b0;
  logic       RST_i = 1'b0;
  logic [7:0] KEYS_i = '0;
  logic       TOGGLE_CLR_i = 1'b0;
  logic       EV_READY_i = 1'b0;
  logic       OVF_CLR_i = 1'b0;
  logic [7:0] STATE_o, PRESS_o, RELEASE_o, REPEAT_o, TOGGLE_o;
  logic       EV_VALID_o, EV_OVF_o;
  logic [4:0] EV_DAT_o;

  int n_tests = 0;
  int n_fail  = 0;

  tm1638_key_event #(
    .C_FCK(1000), .C_FTICK(100), .C_DEB_N(DEB),
    .C_REP_DLY(DLY), .C_REP_PER(PER), .C_FIFO_DEPTH(4)
  ) dut (
    .CK_i(CK_i), .RST_i(RST_i), .KEYS_i(KEYS_i),
    .STATE_o(STATE_o), .PRESS_o(PRESS_o), .RELEASE_o(RELEASE_o),
    .REPEAT_o(REPEAT_o), .TOGGLE_o(TOGGLE_o), .TOGGLE_CLR_i(TOGGLE_CLR_i),
    .EV_VALID_o(EV_VALID_o), .EV_DAT_o(EV_DAT_o), .EV_READY_i(EV_READY_i),
    .EV_OVF_o(EV_OVF_o), .OVF_CLR_i(OVF_CLR_i)
  );

  always #5 CK_i = ~CK_i;

  // Reference model: edges since reset release, tick every DIV edges.
  int         ecnt;
  logic [7:0] m_kd, m_state, m_press, m_rel, m_rep, m_tog;
  int         m_deb  [8];
  int         m_held [8];
  logic [4:0] m_q [$];

  task automatic model_edge();
    logic was;
    m_press = '0;
    m_rel   = '0;
    m_rep   = '0;
    if (RST_i) begin
      ecnt = 0; m_kd = '0; m_state = '0; m_tog = '0;
      m_q.delete();
      for (int k = 0; k < 8; k++) begin m_deb[k] = 0; m_held[k] = 0; end
    end else begin
      ecnt++;
      if (ecnt % DIV == 0) begin
        for (int k = 0; k < 8; k++) begin
          was = m_state[k];
          if (m_kd[k] != was) begin
            m_deb[k]++;
            if (m_deb[k] == DEB) begin
              m_state[k] = m_kd[k];
              m_deb[k] = 0;
              if (m_kd[k]) m_press[k] = 1'b1; else m_rel[k] = 1'b1;
            end
          end else begin
            m_deb[k] = 0;
          end
          if (was) begin
            m_held[k]++;
            if (m_held[k] == DLY || (m_held[k] > DLY && (m_held[k] - DLY) % PER == 0))
              m_rep[k] = 1'b1;
          end
          if (!m_state[k]) m_held[k] = 0;
          if (m_press[k]) m_q.push_back({2'b01, 3'(k)});
          if (m_rel[k])   m_q.push_back({2'b10, 3'(k)});
          if (m_rep[k])   m_q.push_back({2'b11, 3'(k)});
        end
        m_tog = m_tog ^ m_press;
      end
      if (TOGGLE_CLR_i) m_tog = '0;
      m_kd = KEYS_i;
    end
  endtask

  always @(posedge CK_i) model_edge();

  task automatic do_reset();
    @(negedge CK_i);
    RST_i = 1'b1;
    repeat (3) @(negedge CK_i);
    RST_i = 1'b0;
  endtask

  task automatic test_reset();
    int p_at = -1;
    logic [7:0] pv = '0;
    KEYS_i = '0; EV_READY_i = 1'b0;
    do_reset();
    n_tests++;
    if ({STATE_o, PRESS_o, RELEASE_o, REPEAT_o, TOGGLE_o, EV_VALID_o, EV_DAT_o, EV_OVF_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%h pr=%h rl=%h rp=%h tg=%h v=%b d=%h o=%b expected all zero",
               STATE_o, PRESS_o, RELEASE_o, REPEAT_o, TOGGLE_o, EV_VALID_o, EV_DAT_o, EV_OVF_o);
    end
    KEYS_i = 8'h01;
    do_reset();
    repeat (45) begin
      @(negedge CK_i);
      if (PRESS_o != 0 && p_at < 0) begin p_at = ecnt; pv = PRESS_o; end
    end
    n_tests++;
    if (p_at != 30) begin n_fail++; $display("FAIL reset_held_press_time: got %0d expected 30", p_at); end
    n_tests++;
    if (pv !== 8'h01) begin n_fail++; $display("FAIL reset_held_press_val: got %h expected 01", pv); end
  endtask

  task automatic test_bounce();
    logic [5:0] pat = 6'b111011;
    int np = 0, p_at = -1, v_at = -1;
    logic [7:0] pv = '0;
    KEYS_i = '0; EV_READY_i = 1'b0;
    do_reset();
    repeat (5) @(negedge CK_i);
    for (int w = 0; w < 6; w++) begin
      KEYS_i = pat[w] ? 8'h04 : 8'h00;
      repeat (10) begin
        @(negedge CK_i);
        if (PRESS_o != 0) begin np++; p_at = ecnt; pv = PRESS_o; end
        if (EV_VALID_o && v_at < 0) v_at = ecnt;
      end
    end
    n_tests++; if (np != 1) begin n_fail++; $display("FAIL bounce_count: got %0d expected 1", np); end
    n_tests++; if (p_at != 60) begin n_fail++; $display("FAIL bounce_time: got %0d expected 60", p_at); end
    n_tests++; if (pv !== 8'h04) begin n_fail++; $display("FAIL bounce_press: got %h expected 04", pv); end
    n_tests++; if (v_at != 62) begin n_fail++; $display("FAIL bounce_valid_time: got %0d expected 62", v_at); end
    n_tests++; if (STATE_o !== 8'h04) begin n_fail++; $display("FAIL bounce_state: got %h expected 04", STATE_o); end
    n_tests++; if (TOGGLE_o !== 8'h04) begin n_fail++; $display("FAIL bounce_toggle: got %h expected 04", TOGGLE_o); end
    n_tests++;
    if (EV_VALID_o !== 1'b1 || EV_DAT_o !== 5'b01_010) begin
      n_fail++; $display("FAIL bounce_fifo: got v=%b d=%b expected v=1 d=01010", EV_VALID_o, EV_DAT_o);
    end
  endtask

  task automatic test_repeat();
    int p_at = -1, r_at = -1;
    int rep_at [$];
    logic [4:0] s [$];
    logic [4:0] exp_s [5] = '{5'b01_000, 5'b11_000, 5'b11_000, 5'b11_000, 5'b10_000};
    KEYS_i = '0; EV_READY_i = 1'b1;
    do_reset();
    repeat (5) @(negedge CK_i);
    for (int w = 0; w < 15; w++) begin
      KEYS_i = (w < 10) ? 8'h01 : 8'h00;
      repeat (10) begin
        @(negedge CK_i);
        if (PRESS_o[0]) p_at = ecnt;
        if (REPEAT_o[0]) rep_at.push_back(ecnt);
        if (RELEASE_o[0]) r_at = ecnt;
        if (EV_VALID_o) s.push_back(EV_DAT_o);
      end
    end
    n_tests++; if (p_at != 30) begin n_fail++; $display("FAIL repeat_press_time: got %0d expected 30", p_at); end
    n_tests++;
    if (rep_at.size() != 3) begin n_fail++; $display("FAIL repeat_count: got %0d expected 3", rep_at.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rep_at[i] != 80 + 20 * i) begin
        n_fail++; $display("FAIL repeat_time_%0d: got %0d expected %0d", i, rep_at[i], 80 + 20 * i);
      end
    end
    n_tests++; if (r_at != 130) begin n_fail++; $display("FAIL repeat_release_time: got %0d expected 130", r_at); end
    n_tests++;
    if (s.size() != 5) begin n_fail++; $display("FAIL repeat_stream_len: got %0d expected 5", s.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (s[i] !== exp_s[i]) begin n_fail++; $display("FAIL repeat_stream_%0d: got %b expected %b", i, s[i], exp_s[i]); end
    end
  endtask

  task automatic test_simultaneous();
    int p_at = -1;
    logic [7:0] pv = '0;
    logic [4:0] s [$];
    int s_at [$];
    KEYS_i = '0; EV_READY_i = 1'b1;
    do_reset();
    repeat (5) @(negedge CK_i);
    KEYS_i = 8'h81;
    repeat (40) begin
      @(negedge CK_i);
      if (PRESS_o != 0) begin p_at = ecnt; pv = PRESS_o; end
      if (EV_VALID_o) begin s.push_back(EV_DAT_o); s_at.push_back(ecnt); end
    end
    n_tests++;
    if (pv !== 8'h81 || p_at != 30) begin n_fail++; $display("FAIL simul_press: got %h@%0d expected 81@30", pv, p_at); end
    n_tests++;
    if (s.size() != 2) begin n_fail++; $display("FAIL simul_stream_len: got %0d expected 2", s.size()); end
    else begin
      n_tests++;
      if (s[0] !== 5'b01_000 || s_at[0] != 32) begin
        n_fail++; $display("FAIL simul_first: got %b@%0d expected 01000@32", s[0], s_at[0]);
      end
      n_tests++;
      if (s[1] !== 5'b01_111 || s_at[1] != 33) begin
        n_fail++; $display("FAIL simul_second: got %b@%0d expected 01111@33", s[1], s_at[1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [4:0] s [$];
    KEYS_i = '0; EV_READY_i = 1'b0;
    do_reset();
    repeat (5) @(negedge CK_i);
    KEYS_i = 8'h1F;
    repeat (30) @(negedge CK_i);
    n_tests++;
    if (EV_OVF_o !== 1'b0 || EV_VALID_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_before_drop: got ovf=%b v=%b expected ovf=0 v=1", EV_OVF_o, EV_VALID_o);
    end
    OVF_CLR_i = 1'b1;
    @(negedge CK_i);
    OVF_CLR_i = 1'b0;
    n_tests++; if (EV_OVF_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", EV_OVF_o); end
    @(negedge CK_i);
    n_tests++; if (EV_OVF_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", EV_OVF_o); end
    OVF_CLR_i = 1'b1;
    @(negedge CK_i);
    OVF_CLR_i = 1'b0;
    n_tests++; if (EV_OVF_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", EV_OVF_o); end
    EV_READY_i = 1'b1;
    repeat (8) begin
      if (EV_VALID_o && EV_READY_i) s.push_back(EV_DAT_o);
      @(negedge CK_i);
    end
    n_tests++;
    if (s.size() != 4) begin n_fail++; $display("FAIL ovf_drain_len: got %0d expected 4", s.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (s[k] !== {2'b01, 3'(k)}) begin n_fail++; $display("FAIL ovf_drain_%0d: got %b expected %b", k, s[k], {2'b01, 3'(k)}); end
    end
    n_tests++; if (EV_VALID_o !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", EV_VALID_o); end
  endtask

  task automatic test_full_pop();
    logic [4:0] s [$];
    KEYS_i = '0; EV_READY_i = 1'b0;
    do_reset();
    repeat (5) @(negedge CK_i);
    KEYS_i = 8'h1F;
    repeat (30) @(negedge CK_i);
    EV_READY_i = 1'b1;
    repeat (10) begin
      if (EV_VALID_o && EV_READY_i) s.push_back(EV_DAT_o);
      @(negedge CK_i);
    end
    n_tests++; if (EV_OVF_o !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b expected 0", EV_OVF_o); end
    n_tests++;
    if (s.size() != 5) begin n_fail++; $display("FAIL fullpop_len: got %0d expected 5", s.size()); end
    else for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (s[k] !== {2'b01, 3'(k)}) begin n_fail++; $display("FAIL fullpop_%0d: got %b expected %b", k, s[k], {2'b01, 3'(k)}); end
    end
  endtask

  task automatic test_toggle();
    int nv = 0;
    KEYS_i = '0; EV_READY_i = 1'b1;
    do_reset();
    repeat (5) @(negedge CK_i);
    for (int w = 0; w < 15; w++) begin
      KEYS_i = ((w / 3) % 2 == 0) ? 8'h20 : 8'h00;
      repeat (10) begin
        @(negedge CK_i);
        if (ecnt == 30) begin
          n_tests++; if (TOGGLE_o !== 8'h20) begin n_fail++; $display("FAIL toggle_first: got %h expected 20", TOGGLE_o); end
        end
        if (ecnt == 90) begin
          n_tests++; if (TOGGLE_o !== 8'h00) begin n_fail++; $display("FAIL toggle_second: got %h expected 00", TOGGLE_o); end
        end
        if (ecnt == 150) begin
          n_tests++;
          if (TOGGLE_o !== 8'h00 || PRESS_o !== 8'h20) begin
            n_fail++; $display("FAIL toggle_clr_wins: got tg=%h pr=%h expected tg=00 pr=20", TOGGLE_o, PRESS_o);
          end
        end
        TOGGLE_CLR_i = (ecnt == 149);
      end
    end
    TOGGLE_CLR_i = 1'b0;
    // Reset while eight press events are still being drained.
    KEYS_i = '0; EV_READY_i = 1'b0;
    do_reset();
    repeat (5) @(negedge CK_i);
    KEYS_i = 8'hFF;
    repeat (28) @(negedge CK_i);
    n_tests++; if (EV_VALID_o !== 1'b1) begin n_fail++; $display("FAIL middrain_pre: got %b expected 1", EV_VALID_o); end
    RST_i = 1'b1; KEYS_i = '0;
    @(negedge CK_i);
    n_tests++;
    if (EV_VALID_o !== 1'b0 || STATE_o !== 8'h00) begin
      n_fail++; $display("FAIL middrain_reset: got v=%b st=%h expected v=0 st=00", EV_VALID_o, STATE_o);
    end
    RST_i = 1'b0; EV_READY_i = 1'b1;
    repeat (40) begin
      @(negedge CK_i);
      if (EV_VALID_o) nv++;
    end
    n_tests++; if (nv != 0) begin n_fail++; $display("FAIL middrain_stale: got %0d events expected 0", nv); end
  endtask

  task automatic test_random();
    logic [4:0] e;
    KEYS_i = '0; EV_READY_i = 1'b1; TOGGLE_CLR_i = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CK_i);
      n_tests++;
      if ({STATE_o, PRESS_o, RELEASE_o, REPEAT_o, TOGGLE_o} !== {m_state, m_press, m_rel, m_rep, m_tog}) begin
        n_fail++;
        $display("FAIL rand_outputs@%0d: got st=%h pr=%h rl=%h rp=%h tg=%h expected st=%h pr=%h rl=%h rp=%h tg=%h",
                 i, STATE_o, PRESS_o, RELEASE_o, REPEAT_o, TOGGLE_o, m_state, m_press, m_rel, m_rep, m_tog);
      end
      if (EV_VALID_o) begin
        n_tests++;
        if (m_q.size() == 0) begin
          n_fail++; $display("FAIL rand_event@%0d: got %b expected no event", i, EV_DAT_o);
        end else begin
          e = m_q.pop_front();
          if (EV_DAT_o !== e) begin n_fail++; $display("FAIL rand_event@%0d: got %b expected %b", i, EV_DAT_o, e); end
        end
      end
      n_tests++;
      if (EV_OVF_o !== 1'b0) begin n_fail++; $display("FAIL rand_ovf@%0d: got %b expected 0", i, EV_OVF_o); end
      if (i < 2880) begin
        if ($urandom_range(24) == 0) KEYS_i = KEYS_i ^ (8'd1 << $urandom_range(7));
        TOGGLE_CLR_i = ($urandom_range(99) == 0);
      end else begin
        KEYS_i = '0;
        TOGGLE_CLR_i = 1'b0;
      end
    end
    n_tests++;
    if (m_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d undelivered expected 0", m_q.size()); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
